// File: rtl/npc_ctrl_if.sv
// npc_ctrl_if: handshake bundle between the NPC sequencer and the rest of
// the core (fetch unit, load/store unit, decode, register file, PC).
// The sequencer connects through the master modport; the surrounding
// datapath (or a testbench) uses the slave modport.
interface npc_ctrl_if;
  logic        ifu_req;
  logic        ifu_ack;
  logic [31:0] inst_in;
  logic [31:0] ir;
  logic        lsu_req;
  logic        lsu_we;
  logic        lsu_done;
  logic        rf_we;
  logic        pc_we;
  logic        halt;
  logic        halt_err;
  logic [2:0]  state;

  modport master (
    output ifu_req, ir, lsu_req, lsu_we, rf_we, pc_we, halt, halt_err, state,
    input  ifu_ack, inst_in, lsu_done
  );

  modport slave (
    input  ifu_req, ir, lsu_req, lsu_we, rf_we, pc_we, halt, halt_err, state,
    output ifu_ack, inst_in, lsu_done
  );
endinterface

// File: rtl/npc_ctrl.sv
// npc_ctrl: multi-cycle sequencer for the NPC core.
// Walks one instruction at a time through IDLE/FETCH/DECODE/EXEC/MEM/WB,
// owns the instruction register, and parks in HALT on ebreak or on a
// request that waits TIMEOUT cycles without its ack/done.
// Optional build macro NPC_CTRL_PERF_EN adds the 64-bit cycle_cnt and
// instret_cnt performance counters; without it neither port nor counter
// logic exists and the FSM is unchanged.
module npc_ctrl #(
  parameter int unsigned TIMEOUT = 255  // 1..65535
) (
  input  logic          clk,
  input  logic          rst_n,
  npc_ctrl_if.master    bus
`ifdef NPC_CTRL_PERF_EN
  ,
  output logic [63:0]   cycle_cnt,
  output logic [63:0]   instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;

  // The wait counter holds the number of cycles already spent in the
  // current state, so the TIMEOUT-th waiting cycle sees TIMEOUT-1.
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] ir_q, ir_d;
  logic        halt_err_q, halt_err_d;

  logic        is_load;
  logic        is_store;
  logic        is_branch;
  logic        tmo_hit;

  assign is_load   = (ir_q[6:0] == OP_LOAD);
  assign is_store  = (ir_q[6:0] == OP_STORE);
  assign is_branch = (ir_q[6:0] == OP_BRANCH);
  assign tmo_hit   = (tmo_q >= TMO_LAST);

  // State, instruction register, wait counter and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tmo_q      <= '0;
      ir_q       <= '0;
      halt_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      ir_q       <= ir_d;
      halt_err_q <= halt_err_d;
    end
  end

  // Next-state logic; an ack/done in the last allowed cycle beats the timeout.
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    ir_d       = ir_q;
    halt_err_d = halt_err_q;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.ifu_ack) begin
          ir_d    = bus.inst_in;
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d    = S_HALT;
          halt_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_DECODE: state_d = (ir_q == EBREAK) ? S_HALT : S_EXEC;
      S_EXEC:   state_d = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.lsu_done) begin
          state_d = S_WB;
        end else if (tmo_hit) begin
          state_d    = S_HALT;
          halt_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_WB:   state_d = S_FETCH;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // Every state starts its wait count from zero.
    if (state_d != state_q) begin
      tmo_d = '0;
    end
  end

  // Strobes decode straight from the state register (no extra logic depth
  // on the inputs, so they only change right after clk).
  assign bus.ifu_req  = (state_q == S_FETCH);
  assign bus.lsu_req  = (state_q == S_MEM);
  assign bus.lsu_we   = (state_q == S_MEM) && is_store;
  assign bus.pc_we    = (state_q == S_WB);
  assign bus.rf_we    = (state_q == S_WB) && !is_store && !is_branch;
  assign bus.halt     = (state_q == S_HALT);
  assign bus.halt_err = halt_err_q;
  assign bus.ir       = ir_q;
  assign bus.state    = state_q;

`ifdef NPC_CTRL_PERF_EN
  logic [63:0] cycle_q;
  logic [63:0] instret_q;

  // Active-cycle and retired-instruction counters, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALT) begin
        cycle_q <= cycle_q + 64'd1;
      end
      if (state_q == S_WB) begin
        instret_q <= instret_q + 64'd1;
      end
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_npc_ctrl.sv
// tb_npc_ctrl: self-checking bench for npc_ctrl (TIMEOUT=4).
// A directed table of instruction/latency records with hand-derived
// expectations, a few multi-cycle sequences (ebreak park, reset mid-MEM,
// back-to-back fetch), then randomized instructions whose expected
// per-instruction outcome comes from a latency/classification model.
module tb_npc_ctrl;
  localparam int          TMO    = 4;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ADDI   = 32'h0010_0093;
  localparam logic [31:0] LW     = 32'h0000_2103;
  localparam logic [31:0] SW     = 32'h0020_2023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  npc_ctrl_if bus ();

`ifdef NPC_CTRL_PERF_EN
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;
`endif

  npc_ctrl #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef NPC_CTRL_PERF_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  // Per-instruction outcome as seen from outside the block.
  typedef struct packed {
    logic [7:0]  lat;       // cycle of pc_we counted from FETCH entry (1-based)
    logic [3:0]  pcwe_n;    // number of pc_we cycles
    logic [3:0]  rfwe_n;    // number of rf_we cycles
    logic        lsuwe;     // lsu_we seen while lsu_req
    logic        lsureq;    // lsu_req seen
    logic        halt;
    logic        err;
    logic [7:0]  halt_cyc;  // first cycle with halt=1
    logic [31:0] ir;
  } obs_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [7:0]  fdly;      // wait cycles before ifu_ack
    logic [7:0]  mdly;      // wait cycles before lsu_done
    obs_t        exp;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic vec_t mkv(logic [31:0] inst, int f, int m, int lat, int pc, int rf,
                               int lwe, int lreq, int h, int e, int hc, logic [31:0] ir);
    vec_t v;
    v.inst         = inst;
    v.fdly         = 8'(f);
    v.mdly         = 8'(m);
    v.exp.lat      = 8'(lat);
    v.exp.pcwe_n   = 4'(pc);
    v.exp.rfwe_n   = 4'(rf);
    v.exp.lsuwe    = lwe[0];
    v.exp.lsureq   = lreq[0];
    v.exp.halt     = h[0];
    v.exp.err      = e[0];
    v.exp.halt_cyc = 8'(hc);
    v.exp.ir       = ir;
    return v;
  endfunction

  // Reference model: outcome of one instruction from the sequencing rules.
  function automatic obs_t model(logic [31:0] inst, int f, int m, logic [31:0] prev_ir);
    obs_t e;
    logic [6:0] op;
    logic ldst;
    op   = inst[6:0];
    ldst = (op == 7'h03) || (op == 7'h23);
    e = '0;
    if (f >= TMO) begin
      e.halt = 1'b1; e.err = 1'b1; e.halt_cyc = 8'(TMO + 1); e.ir = prev_ir;
    end else if (inst == EBREAK) begin
      e.halt = 1'b1; e.halt_cyc = 8'(f + 3); e.ir = inst;
    end else if (ldst && m >= TMO) begin
      e.halt = 1'b1; e.err = 1'b1; e.lsureq = 1'b1; e.lsuwe = (op == 7'h23);
      e.halt_cyc = 8'(f + 1 + 2 + TMO + 1); e.ir = inst;
    end else begin
      e.lat    = 8'(f + 1 + 2 + (ldst ? m + 1 : 0) + 1);
      e.pcwe_n = 4'd1;
      e.rfwe_n = (op == 7'h23 || op == 7'h63) ? 4'd0 : 4'd1;
      e.lsureq = ldst;
      e.lsuwe  = (op == 7'h23);
      e.ir     = inst;
    end
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.ifu_ack = 1'b0;
    bus.lsu_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one instruction starting from a FETCH entry; returns at the
  // negedge of the WB cycle or of the first HALT cycle.
  task automatic exec_one(input string p, input logic [31:0] inst, input int fdly,
                          input int mdly, output obs_t o);
    int c, fcnt, mcnt, enc_bad;
    logic done;
    o = '0; c = 0; fcnt = 0; mcnt = 0; enc_bad = 0; done = 1'b0;
    while (!done && c < 60) begin
      @(negedge clk);
      c++;
      if (bus.ifu_req !== (bus.state == 3'd1) || bus.lsu_req !== (bus.state == 3'd4) ||
          bus.pc_we !== (bus.state == 3'd5) || bus.halt !== (bus.state == 3'd6))
        enc_bad++;
      if (bus.pc_we) begin o.pcwe_n = o.pcwe_n + 4'd1; o.lat = 8'(c); end
      if (bus.rf_we) o.rfwe_n = o.rfwe_n + 4'd1;
      if (bus.lsu_req) begin
        o.lsureq = 1'b1;
        if (bus.lsu_we) o.lsuwe = 1'b1;
      end
      if (bus.halt) begin o.halt = 1'b1; o.halt_cyc = 8'(c); end
      if (bus.ifu_req) begin
        bus.ifu_ack = (fcnt == fdly);
        bus.inst_in = (fcnt == fdly) ? inst : $urandom;
        fcnt++;
      end else begin
        bus.ifu_ack = 1'($urandom_range(0, 1));
        bus.inst_in = $urandom;
      end
      if (bus.lsu_req) begin
        bus.lsu_done = (mcnt == mdly);
        mcnt++;
      end else begin
        bus.lsu_done = 1'($urandom_range(0, 1));
      end
      if (bus.pc_we || bus.halt) done = 1'b1;
    end
    o.err = bus.halt_err;
    o.ir  = bus.ir;
    chk({p, ".bound"}, 64'(done), 64'd1);
    chk({p, ".enc"}, 64'(enc_bad), 64'd0);
  endtask

  task automatic cmp(input string p, input obs_t a, input obs_t e);
    chk({p, ".lat"},    64'(a.lat),      64'(e.lat));
    chk({p, ".pc_we"},  64'(a.pcwe_n),   64'(e.pcwe_n));
    chk({p, ".rf_we"},  64'(a.rfwe_n),   64'(e.rfwe_n));
    chk({p, ".lsu_we"}, 64'(a.lsuwe),    64'(e.lsuwe));
    chk({p, ".lsu_rq"}, 64'(a.lsureq),   64'(e.lsureq));
    chk({p, ".halt"},   64'(a.halt),     64'(e.halt));
    chk({p, ".err"},    64'(a.err),      64'(e.err));
    chk({p, ".hcyc"},   64'(a.halt_cyc), 64'(e.halt_cyc));
    chk({p, ".ir"},     64'(a.ir),       64'(e.ir));
  endtask

  vec_t vecs [11];

  initial begin
    obs_t o, e;
    logic [31:0] prev_ir;
    int cnt;

    //              inst      f  m  lat pc rf lwe lrq h  e  hc  ir
    vecs[0]  = mkv(ADDI,        0, 0, 4, 1, 1, 0, 0, 0, 0, 0, ADDI);
    vecs[1]  = mkv(LW,          0, 3, 8, 1, 1, 0, 1, 0, 0, 0, LW);
    vecs[2]  = mkv(SW,          1, 0, 6, 1, 0, 1, 1, 0, 0, 0, SW);
    vecs[3]  = mkv(32'h0000_0063, 2, 0, 6, 1, 0, 0, 0, 0, 0, 0, 32'h0000_0063);
    vecs[4]  = mkv(32'h0000_007f, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 32'h0000_007f);
    vecs[5]  = mkv(ADDI,        3, 0, 7, 1, 1, 0, 0, 0, 0, 0, ADDI);
    vecs[6]  = mkv(SW,          0, 3, 8, 1, 0, 1, 1, 0, 0, 0, SW);
    vecs[7]  = mkv(EBREAK,      0, 0, 0, 0, 0, 0, 0, 1, 0, 3, EBREAK);
    vecs[8]  = mkv(ADDI,        4, 0, 0, 0, 0, 0, 0, 1, 1, 5, 32'h0);
    vecs[9]  = mkv(LW,          0, 4, 0, 0, 0, 0, 1, 1, 1, 8, LW);
    vecs[10] = mkv(ADDI,        0, 0, 4, 1, 1, 0, 0, 0, 0, 0, ADDI);

    bus.ifu_ack = 1'b0; bus.inst_in = '0; bus.lsu_done = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.state",  64'(bus.state), 64'd0);
    chk("rst.ir",     64'(bus.ir), 64'd0);
    chk("rst.halt",   64'({bus.halt, bus.halt_err}), 64'd0);
    chk("rst.strobe", 64'({bus.ifu_req, bus.lsu_req, bus.lsu_we, bus.rf_we, bus.pc_we}), 64'd0);
`ifdef NPC_CTRL_PERF_EN
    chk("rst.perf", cycle_cnt | instret_cnt, 64'd0);
`endif
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      exec_one($sformatf("v%0d", i), vecs[i].inst, int'(vecs[i].fdly), int'(vecs[i].mdly), o);
      cmp($sformatf("v%0d", i), o, vecs[i].exp);
      $display("vec %0d inst=%08h lat=%0d halt=%0d err=%0d", i, vecs[i].inst, o.lat, o.halt, o.err);
      if (vecs[i].exp.halt || o.halt || o.pcwe_n == 0) do_reset();
    end

    // ebreak parks the core: no fetch or writeback for 100 cycles.
    do_reset();
    exec_one("eb", EBREAK, 0, 0, o);
    chk("eb.state", 64'(bus.state), 64'd6);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus.ifu_ack = 1'($urandom_range(0, 1));
      bus.lsu_done = 1'($urandom_range(0, 1));
      if (bus.ifu_req || bus.pc_we || bus.rf_we || bus.lsu_req || !bus.halt || bus.halt_err) cnt++;
    end
    chk("eb.parked", 64'(cnt), 64'd0);
    $display("seq ebreak park bad_cycles=%0d", cnt);

    // Back-to-back: FETCH directly follows WB; counters after one retire.
    do_reset();
    exec_one("b2b", ADDI, 0, 0, o);
    bus.ifu_ack = 1'b0;
    @(negedge clk);
    chk("b2b.state", 64'(bus.state), 64'd1);
`ifdef NPC_CTRL_PERF_EN
    chk("b2b.instret", instret_cnt, 64'd1);
    chk("b2b.cycle", cycle_cnt, 64'd4);
`endif
    $display("seq back-to-back state=%0d", bus.state);

    // Reset asserted in the middle of MEM.
    do_reset();
    @(negedge clk);
    bus.ifu_ack = 1'b1; bus.inst_in = LW; bus.lsu_done = 1'b0;
    @(negedge clk);
    bus.ifu_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rmem.req", 64'(bus.lsu_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rmem.drop", 64'({bus.lsu_req, bus.state}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rmem.idle", 64'(bus.state), 64'd0);
    @(negedge clk);
    chk("rmem.fetch", 64'(bus.state), 64'd1);
`ifdef NPC_CTRL_PERF_EN
    chk("rmem.cyc0", cycle_cnt, 64'd0);
    @(negedge clk);
    chk("rmem.cyc1", cycle_cnt, 64'd1);
`endif
    $display("seq reset-mid-mem state=%0d", bus.state);

    // Randomized instructions against the model.
    do_reset();
    prev_ir = '0;
    for (int i = 0; i < 200; i++) begin
      logic [31:0] r, inst;
      logic [6:0] op;
      int f, m;
      r = $urandom;
      case ($urandom_range(0, 7))
        0: op = 7'h13;
        1: op = 7'h03;
        2: op = 7'h23;
        3: op = 7'h63;
        4: op = 7'h6f;
        5: op = 7'h33;
        6: op = r[6:0];
        default: op = 7'h37;
      endcase
      inst = {r[31:7], op};
      if ($urandom_range(0, 11) == 0) inst = EBREAK;
      f = ($urandom_range(0, 11) == 0) ? TMO : int'($urandom_range(0, TMO - 1));
      m = ($urandom_range(0, 7) == 0) ? TMO : int'($urandom_range(0, TMO - 1));
      e = model(inst, f, m, prev_ir);
      exec_one($sformatf("r%0d", i), inst, f, m, o);
      cmp($sformatf("r%0d", i), o, e);
      $display("rnd %0d inst=%08h f=%0d m=%0d lat=%0d halt=%0d err=%0d", i, inst, f, m,
               o.lat, o.halt, o.err);
      prev_ir = e.ir;
      if (e.halt || o.halt || o.pcwe_n == 0) begin
        do_reset();
        prev_ir = '0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
